serial_sum_deserializer: RTL and testbench

// - Receive end of the bit-serial adder datapath: collects the LSB-first sum bitstream and the adder's carry.
// - Assembles each WIDTH-bit frame into a parallel word with a carry-out flag.
// - Presents the word on a valid/ready interface.
// - A one-entry output register lets the next frame be collected while the previous word waits for the consumer.

---
 rtl/serial_sum_deserializer.sv | 78 +++++++
 tb/tb_serial_sum_deserializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sum_deserializer.sv
// Receive end of the bit-serial adder: gathers an LSB-first sum stream plus the
// final carry into a parallel word held in a one-entry valid/ready output register.
module serial_sum_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_carry,
  input  logic             in_sync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             sync_err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_idx;
  logic [CW-1:0]    w_cnt_next;
  logic             w_accept;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;

  assign in_ready   = !((r_cnt == LAST) && out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_idx      = in_sync ? '0 : r_cnt;
  assign w_complete = w_accept && (w_idx == LAST);
  assign w_cnt_next = (w_idx == LAST) ? '0 : w_idx + CW'(1);

  // Only sr[WIDTH-1:1] is ever observed, so bit 0 of the shift register is not stored.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_word = in_bit;
    end else begin : g_wn
      logic [WIDTH-2:0] r_sr;
      assign w_word = {in_bit, r_sr};
      if (WIDTH == 2) begin : g_w2
        always_ff @(posedge clk) begin
          if (!rst)          r_sr <= '0;
          else if (w_accept) r_sr <= in_bit;
        end
      end else begin : g_wbig
        always_ff @(posedge clk) begin
          if (!rst)          r_sr <= '0;
          else if (w_accept) r_sr <= {in_bit, r_sr[WIDTH-2:1]};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= w_accept && in_sync && (r_cnt != '0);
      if (w_accept) r_cnt <= w_cnt_next;
      // A completing frame is never stalled here, since in_ready blocks it while the register is full.
      if (w_complete) begin
        out_data  <= w_word;
        out_carry <= in_carry;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Directed bench for serial_sum_deserializer (WIDTH=8): one task per scenario,
// with a monitor logging handshaked words, sync_err pulses and out_valid rises.
module tb_serial_sum_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_bit, in_carry, in_sync;
  logic       out_valid, out_ready, out_carry, sync_err;
  logic [7:0] out_data;

  int total = 0;
  int bad   = 0;

  logic [8:0] cap_q[$];
  int         err_pulses = 0;
  int         rises = 0;
  logic       prev_v = 1'b0;

  always #5 clk = ~clk;

  serial_sum_deserializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .in_carry(in_carry), .in_sync(in_sync),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .sync_err(sync_err)
  );

  always @(posedge clk) begin
    if (rst && out_valid && out_ready) cap_q.push_back({out_carry, out_data});
    if (rst && sync_err) err_pulses++;
    if (out_valid && !prev_v) rises++;
    prev_v = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cap_q.delete();
    err_pulses = 0;
    rises = 0;
  endtask

  // Presents one bit and returns 1 time unit after the edge that accepts it.
  task automatic send_bit(input logic b, input logic sync, input logic carry);
    int waited;
    in_valid = 1'b1;
    in_bit   = b;
    in_sync  = sync;
    in_carry = carry;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) begin
      total++; bad++;
      $display("FAIL send_bit_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic carry, input logic sync_first,
                            input int gap_max);
    for (int i = 0; i < 8; i++) begin
      if (gap_max > 0 && i > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, gap_max)) tick();
      end
      send_bit(d[i], sync_first && (i == 0), (i == 7) ? carry : 1'b0);
    end
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic check_word(input string name, input logic [7:0] d, input logic c);
    total++;
    if (out_valid !== 1'b1 || out_data !== d || out_carry !== c) begin
      bad++;
      $display("FAIL %s: valid=%0b data=%02h carry=%0b required valid=1 data=%02h carry=%0b",
               name, out_valid, out_data, out_carry, d, c);
    end
  endtask

  task automatic check_cap(input string name, input int idx, input logic [8:0] exp);
    total++;
    if (cap_q.size() <= idx) begin
      bad++;
      $display("FAIL %s: only %0d words consumed, required entry %0d = %03h", name, cap_q.size(), idx, exp);
    end else if (cap_q[idx] !== exp) begin
      bad++;
      $display("FAIL %s: consumed %03h required %03h", name, cap_q[idx], exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    check_bit("reset_out_valid", out_valid, 1'b0);
    total++;
    if (out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_out_data: got %02h required 00", out_data);
    end
    check_bit("reset_out_carry", out_carry, 1'b0);
    check_bit("reset_sync_err", sync_err, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    clear_mon();
    out_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check_word("single_word", 8'hA5, 1'b1);
    tick();
    check_bit("single_valid_drop", out_valid, 1'b0);
    check_int("single_count", cap_q.size(), 1);
    check_cap("single_cap", 0, 9'h1A5);
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    clear_mon();
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    check_word("bp_first", 8'h3C, 1'b0);
    d = 8'hC3;
    for (int i = 0; i < 7; i++) send_bit(d[i], i == 0, 1'b0);
    in_valid = 1'b1; in_bit = d[7]; in_sync = 1'b0; in_carry = 1'b1;
    #1;
    check_bit("bp_stall_ready", in_ready, 1'b0);
    repeat (2) tick();
    check_word("bp_hold", 8'h3C, 1'b0);
    check_bit("bp_still_stalled", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check_bit("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_word("bp_second", 8'hC3, 1'b1);
    tick();
    check_bit("bp_valid_drop", out_valid, 1'b0);
    check_int("bp_count", cap_q.size(), 2);
    check_cap("bp_cap0", 0, 9'h03C);
    check_cap("bp_cap1", 1, 9'h1C3);
  endtask

  task automatic test_resync();
    clear_mon();
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    check_bit("resync_no_err_before", sync_err, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    check_bit("resync_err_pulse", sync_err, 1'b1);
    send_bit(1'b1, 1'b0, 1'b0);
    check_bit("resync_err_clear", sync_err, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_word("resync_word", 8'h5A, 1'b1);
    tick();
    check_int("resync_err_count", err_pulses, 1);
    check_int("resync_count", cap_q.size(), 1);
    check_cap("resync_cap", 0, 9'h15A);
  endtask

  task automatic test_reset_mid();
    clear_mon();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'b0, i == 0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_bit("rstmid_valid", out_valid, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 0);
    check_word("rstmid_word", 8'hFF, 1'b0);
    tick();
    check_int("rstmid_count", cap_q.size(), 1);
    check_cap("rstmid_cap", 0, 9'h0FF);
  endtask

  task automatic test_gaps();
    clear_mon();
    out_ready = 1'b1;
    send_frame(8'h81, 1'b1, 1'b1, 3);
    check_word("gaps_word", 8'h81, 1'b1);
    tick();
    check_int("gaps_rises", rises, 1);
    check_int("gaps_count", cap_q.size(), 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    clear_mon();
    out_ready = 1'b1;
    a = 8'h12;
    b = 8'h34;
    for (int i = 0; i < 8; i++) send_bit(a[i], i == 0, i == 7);
    check_word("b2b_first", 8'h12, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(b[i], i == 0, 1'b0);
    in_valid = 1'b0;
    check_word("b2b_second", 8'h34, 1'b0);
    tick();
    check_int("b2b_count", cap_q.size(), 2);
    check_cap("b2b_cap0", 0, 9'h112);
    check_cap("b2b_cap1", 1, 9'h034);
    check_int("b2b_err_count", err_pulses, 0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_carry = 1'b0;
    in_sync = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_resync();
    test_reset_mid();
    test_gaps();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
